// File: rtl/dual_grant_decoder_pkg.sv
// Shared types and helpers for the dual grant decoder.
// Contents:
//   state_t      grant FSM state encoding
//   DEF_N        default requester count
//   DEF_CODE_W   default code width
//   CODE_NONE    code value meaning "no request"
//   code_legal   1 when a code names a real requester (1..n)
package dual_grant_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  localparam int unsigned DEF_N      = 12;
  localparam int unsigned DEF_CODE_W = 4;

  localparam logic [DEF_CODE_W-1:0] CODE_NONE = '0;

  function automatic logic code_legal(input int unsigned code, input int unsigned n);
    return (code != 0) && (code <= n);
  endfunction

endpackage

// File: rtl/dual_grant_decoder_onehot.sv
// Combinational code to one-hot converter.
// Ports:
//   i_code    request code, 1..N selects bit code-1
//   o_onehot  N-bit one-hot; all zero for "none" (0) or an illegal code (>N)
module code_to_onehot
  import dual_grant_pkg::*;
#(
  parameter int unsigned N      = DEF_N,
  parameter int unsigned CODE_W = DEF_CODE_W
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [N-1:0]      o_onehot
);

  logic [N-1:0] w_one;

  assign w_one = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    o_onehot = '0;
    if (code_legal(32'(i_code), N)) begin
      o_onehot = w_one << (i_code - 1'b1);
    end
  end

endmodule

// File: rtl/dual_grant_decoder.sv
// Dual grant decoder: accepts a {first, second} code pair over valid/ready and
// presents the legal, distinct codes as one-hot grants one after the other,
// each held until grant_ack.
//
// Build option: define DUAL_GRANT_TIMEOUT_EN to add a per-grant timer that
// force-releases a grant after TIMEOUT unacknowledged cycles and pulses
// timeout. Without it grants are held indefinitely and timeout is 0.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      code pair valid
//   in_ready      decoder idle and able to take a pair
//   first/second  priority-ordered request codes (0 = none, >N illegal)
//   grant         one-hot grant, bit k-1 for code k
//   grant_valid   a grant is being presented
//   grant_idx     code currently granted, 0 when idle
//   grant_ack     agent accepts the current grant
//   code_err      one-cycle pulse after accepting a pair with an illegal code
//   timeout       one-cycle pulse when a grant is force-released
//
// State table:
//   state | meaning
//   IDLE  | no grant; in_ready high, waiting for a pair
//   GNT1  | presenting first grant; second may still be pending
//   GNT2  | presenting the last grant of the pair
module dual_grant_decoder
  import dual_grant_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned CODE_W  = DEF_CODE_W
`ifdef DUAL_GRANT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] first,
  input  logic [CODE_W-1:0] second,
  output logic [N-1:0]      grant,
  output logic              grant_valid,
  output logic [CODE_W-1:0] grant_idx,
  input  logic              grant_ack,
  output logic              code_err,
  output logic              timeout
);

  localparam logic [CODE_W-1:0] NONE = CODE_W'(CODE_NONE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_second;
  logic [CODE_W-1:0] w_second_nxt;
  logic [CODE_W-1:0] r_grant_idx;
  logic [CODE_W-1:0] w_idx_nxt;
  logic [N-1:0]      r_grant;
  logic [N-1:0]      w_onehot_nxt;
  logic              r_in_ready;
  logic              r_grant_valid;
  logic              r_code_err;
  logic              r_timeout;

  logic w_transfer;
  logic w_first_ok;
  logic w_second_ok;
  logic w_code_err_nxt;
  logic w_expire;
  logic w_done;
  logic w_timeout_nxt;

  assign w_transfer  = in_valid & r_in_ready;
  assign w_first_ok  = code_legal(32'(first), N);
  // A second code equal to the first would just repeat the same grant.
  assign w_second_ok = code_legal(32'(second), N) && (second != first);

  assign w_code_err_nxt = w_transfer && ((32'(first) > N) || (32'(second) > N));

  assign w_done = grant_ack | w_expire;

`ifdef DUAL_GRANT_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] r_tmr;

  // Reloaded on every state change, so each grant gets a full TIMEOUT window;
  // terminal count 0 in a grant state means TIMEOUT cycles passed without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= TMR_W'(TIMEOUT - 1);
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  assign w_expire = (r_state != IDLE) && (r_tmr == '0);
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_grant_idx;
    w_second_nxt  = r_second;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_idx_nxt = NONE;
        if (w_transfer) begin
          if (w_first_ok) begin
            w_state_nxt  = GNT1;
            w_idx_nxt    = first;
            w_second_nxt = w_second_ok ? second : NONE;
          end else if (w_second_ok) begin
            w_state_nxt  = GNT2;
            w_idx_nxt    = second;
            w_second_nxt = NONE;
          end
        end
      end
      GNT1: begin
        if (w_done) begin
          // An ack in the expiry cycle wins: no timeout pulse.
          w_timeout_nxt = ~grant_ack;
          if (r_second != NONE) begin
            w_state_nxt  = GNT2;
            w_idx_nxt    = r_second;
            w_second_nxt = NONE;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = NONE;
          end
        end
      end
      GNT2: begin
        if (w_done) begin
          w_timeout_nxt = ~grant_ack;
          w_state_nxt   = IDLE;
          w_idx_nxt     = NONE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_idx_nxt    = NONE;
        w_second_nxt = NONE;
      end
    endcase
  end

  code_to_onehot #(
    .N      (N),
    .CODE_W (CODE_W)
  ) u_onehot (
    .i_code   (w_idx_nxt),
    .o_onehot (w_onehot_nxt)
  );

  // Outputs are registered from next-state values so they change together
  // with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_second      <= '0;
      r_grant_idx   <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_in_ready    <= 1'b0;
      r_code_err    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_second      <= w_second_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_grant       <= w_onehot_nxt;
      r_grant_valid <= (w_state_nxt != IDLE);
      r_in_ready    <= (w_state_nxt == IDLE);
      r_code_err    <= w_code_err_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign code_err    = r_code_err;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_dual_grant_decoder.sv
module tb_dual_grant_decoder;

  localparam int N       = 12;
  localparam int TIMEOUT = 16;
`ifdef DUAL_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  first;
  logic [3:0]  second;
  logic [11:0] grant;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        grant_ack;
  logic        code_err;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  s;
    logic [11:0] g1;
    logic [11:0] g2;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a queue of codes still to be granted.
  int q[$];
  int m_age;
  bit m_ready;
  bit m_err;
  bit m_to;

  always #5 clk = ~clk;

  dual_grant_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .first       (first),
    .second      (second),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_ack   (grant_ack),
    .code_err    (code_err),
    .timeout     (timeout)
  );

  function automatic bit legal(input int c);
    return (c >= 1) && (c <= N);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int f;
    int s;
    m_err = 1'b0;
    m_to  = 1'b0;
    if (rst) begin
      q.delete();
      m_age   = 0;
      m_ready = 1'b0;
      return;
    end
    if (q.size() > 0) begin
      if (grant_ack) begin
        void'(q.pop_front());
        m_age = 0;
      end else begin
        m_age++;
        if (TO_EN && m_age == TIMEOUT) begin
          void'(q.pop_front());
          m_age = 0;
          m_to  = 1'b1;
        end
      end
    end else if (m_ready && in_valid) begin
      f = int'(first);
      s = int'(second);
      if (legal(f)) q.push_back(f);
      if (legal(s) && s != f) q.push_back(s);
      m_err = (f > N) || (s > N);
      m_age = 0;
    end
    m_ready = (q.size() == 0);
  endtask

  task automatic check_model();
    int          idx;
    logic [11:0] one;
    logic [11:0] eg;
    one = 12'd1;
    idx = (q.size() > 0) ? q[0] : 0;
    eg  = (idx > 0) ? (one << (idx - 1)) : 12'd0;
    check("mdl_in_ready", in_ready, m_ready);
    check("mdl_grant_valid", grant_valid, q.size() > 0);
    check("mdl_grant_idx", grant_idx, idx);
    check("mdl_grant", grant, eg);
    check("mdl_code_err", code_err, m_err);
    check("mdl_timeout", timeout, m_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waited;
    bit  seen;

    in_valid  = 1'b0;
    first     = 4'd0;
    second    = 4'd0;
    grant_ack = 1'b0;
    q.delete();
    m_age   = 0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_to    = 1'b0;

    vecs.push_back('{4'd5,  4'd2,  12'h010, 12'h002, 1'b0});
    vecs.push_back('{4'd7,  4'd7,  12'h040, 12'h000, 1'b0});
    vecs.push_back('{4'd0,  4'd4,  12'h008, 12'h000, 1'b0});
    vecs.push_back('{4'd13, 4'd1,  12'h001, 12'h000, 1'b1});
    vecs.push_back('{4'd0,  4'd0,  12'h000, 12'h000, 1'b0});
    vecs.push_back('{4'd12, 4'd15, 12'h800, 12'h000, 1'b1});
    vecs.push_back('{4'd14, 4'd14, 12'h000, 12'h000, 1'b1});
    vecs.push_back('{4'd1,  4'd12, 12'h001, 12'h800, 1'b0});
    vecs.push_back('{4'd3,  4'd0,  12'h004, 12'h000, 1'b0});

    // Power-on reset
    #1 rst = 1'b1;
    #1;
    check("rst_grant", grant, 12'h000);
    check("rst_grant_valid", grant_valid, 1'b0);
    check("rst_grant_idx", grant_idx, 4'd0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_code_err", code_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_release_ready", in_ready, 1'b1);

    // Table-driven pairs
    foreach (vecs[i]) begin
      check("tbl_idle_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      first    = vecs[i].f;
      second   = vecs[i].s;
      step();
      in_valid = 1'b0;
      first    = 4'd0;
      second   = 4'd0;
      check("tbl_code_err", code_err, vecs[i].err);
      check("tbl_g1", grant, vecs[i].g1);
      if (vecs[i].g1 == 12'h000) begin
        check("tbl_none_ready", in_ready, 1'b1);
      end else begin
        step();
        step();
        check("tbl_g1_hold", grant, vecs[i].g1);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        check("tbl_g2", grant, vecs[i].g2);
        if (vecs[i].g2 != 12'h000) begin
          step();
          grant_ack = 1'b1;
          step();
          grant_ack = 1'b0;
        end
        check("tbl_ready_after", in_ready, 1'b1);
      end
    end

    // Async reset in the middle of a grant
    in_valid = 1'b1;
    first    = 4'd3;
    second   = 4'd0;
    step();
    in_valid = 1'b0;
    first    = 4'd0;
    check("rstmid_pre_grant", grant, 12'h004);
    #3 rst = 1'b1;
    #1;
    check("rstmid_grant", grant, 12'h000);
    check("rstmid_grant_valid", grant_valid, 1'b0);
    check("rstmid_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("rstmid_idle_ready", in_ready, 1'b1);
    check("rstmid_idle_gv", grant_valid, 1'b0);

    // Streamed pairs with ack held high
    in_valid  = 1'b1;
    first     = 4'd1;
    second    = 4'd12;
    grant_ack = 1'b1;
    step();
    check("strm_g0", grant, 12'h001);
    first  = 4'd6;
    second = 4'd0;
    step();
    check("strm_g1", grant, 12'h800);
    step();
    check("strm_idle_grant", grant, 12'h000);
    check("strm_idle_ready", in_ready, 1'b1);
    step();
    check("strm_g2", grant, 12'h020);
    in_valid = 1'b0;
    first    = 4'd0;
    step();
    check("strm_end_ready", in_ready, 1'b1);
    for (int c = 0; c < 3; c++) step();
    check("strm_spurious_ack", grant_valid, 1'b0);
    grant_ack = 1'b0;

    // Timeout behaviour
    in_valid = 1'b1;
    first    = 4'd9;
    second   = 4'd10;
    step();
    in_valid = 1'b0;
    first    = 4'd0;
    second   = 4'd0;
    check("to_g1", grant, 12'h100);
`ifdef DUAL_GRANT_TIMEOUT_EN
    waited = 0;
    seen   = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (timeout === 1'b1) begin
        seen   = 1'b1;
        waited = c;
      end
    end
    check("to_seen", seen, 1'b1);
    check("to_cycles", waited, 16);
    check("to_g2", grant, 12'h200);
    for (int c = 0; c < 15; c++) step();
    check("to_g2_hold", grant, 12'h200);
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    check("to_ack_expiry_pulse", timeout, 1'b0);
    check("to_ack_expiry_grant", grant, 12'h000);
    check("to_ack_expiry_ready", in_ready, 1'b1);
`else
    waited = 0;
    seen   = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (timeout !== 1'b0) seen = 1'b1;
    end
    check("noto_pulse_seen", seen, 1'b0);
    check("noto_hold", grant, 12'h100);
    grant_ack = 1'b1;
    step();
    check("noto_g2", grant, 12'h200);
    step();
    grant_ack = 1'b0;
    check("noto_ready", in_ready, 1'b1);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      first     = 4'($urandom_range(0, 15));
      second    = 4'($urandom_range(0, 15));
      grant_ack = ($urandom_range(0, 9) < 3);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    grant_ack = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
